eq_cfg_ctrl: RTL and testbench
==============================

// Module: eq_cfg_ctrl
// PURPOSE
//  Configuration controller between the EQ SPI receiver and the audio EQ datapath.
//  - Decodes 32-bit command words into a shadow bank of per-band gains.
//  - Copies the shadow bank to the active bank only on an audio sample boundary,
//    so the datapath never sees a half-updated gain set.
//  - Reports busy, a sticky error code and a commit counter for debug LEDs.
// PARAMETERS
//  NBANDS        8      number of EQ bands (2..16)
//  GAIN_W        8      gain width, unsigned, unity gain = GAIN_DEFAULT
//  GAIN_DEFAULT  8'h80  reset/restore value for every band
// PORTS
//  clk            in   1              system clock (HSOSC domain)
//  reset          in   1              synchronous, active-high
//  word_valid     in   1              1-cycle pulse: word_data holds a complete SPI word (already in clk domain)
//  word_data      in   32             command word
//  sample_tick    in   1              1-cycle pulse per audio sample
//  band_gain      out  NBANDS*GAIN_W  active gains; band i at [i*GAIN_W +: GAIN_W]
//  cfg_busy       out  1              high in WAIT_TICK or RAMP
//  err_code       out  2              0 = none, 1 = bad opcode, 2 = bad band, 3 = overrun; sticky
//  upd_cnt        out  8              number of completed commits, wraps 255 -> 0
// BEHAVIOUR
//  Reset (sync, active-high): all active and shadow gains = GAIN_DEFAULT, state IDLE,
//    cfg_busy = 0, err_code = 0, upd_cnt = 0. Reset mid-commit or mid-ramp aborts it; no partial apply.
//  Word format: [31:28] opcode, [27:24] band, [GAIN_W-1:0] gain; all other bits are ignored.
//  Opcodes, accepted only in IDLE; each takes effect in the cycle after word_valid:
//    0x1 WRITE   band < NBANDS: shadow[band] = gain. Otherwise err_code = 2, shadow unchanged.
//    0x2 COMMIT  go to WAIT_TICK.
//    0x3 DEFAULT all shadow gains = GAIN_DEFAULT; active bank untouched.
//    0x4 CLR_ERR err_code = 0.
//    any other   err_code = 1.
//  word_valid while cfg_busy: word is dropped and err_code = 3.
//  Error priority: a new error overwrites the stored code. CLR_ERR is the only way to clear it.
//  FSM:
//    IDLE      -> WAIT_TICK  on COMMIT.
//    WAIT_TICK -> on the first sample_tick, including one in the cycle the state is entered:
//                 without EQ_RAMP_EN: active = shadow from the next cycle, upd_cnt++, -> IDLE.
//                 with EQ_RAMP_EN: -> RAMP.
//    RAMP      -> on each sample_tick, every band whose active != shadow moves 1 LSB toward shadow;
//                 the cycle all bands match: upd_cnt++, -> IDLE.
//  Simultaneous word_valid and sample_tick in WAIT_TICK: the tick is serviced; the word is an overrun.
//  COMMIT with shadow == active still waits for a tick and still increments upd_cnt.
//  Gain arithmetic is unsigned with no wrap: a ramp step never passes the target.
// CONFIGURATION
//  EQ_RAMP_EN defined: the RAMP state exists, giving zipper-free transitions.
//    Worst-case commit = 2^GAIN_W - 1 ticks after the first tick.
//  EQ_RAMP_EN undefined: the RAMP state and ramp logic are absent; commit is an instant copy on one tick.
// STRUCTURE
//  Package eq_pkg:
//    - NBANDS_MAX, GAIN_DEFAULT
//    - eq_op_e  {OP_WRITE = 4'h1, OP_COMMIT, OP_DEFAULT, OP_CLR_ERR}
//    - eq_err_e {ERR_NONE, ERR_OPCODE, ERR_BAND, ERR_OVERRUN}
//    - eq_state_e {S_IDLE, S_WAIT_TICK, S_RAMP}
//  Sub-module eq_gain_ramp: one band.
//    - Ports: clk, reset, step, target, value, at_target.
//    - Instantiated NBANDS times under EQ_RAMP_EN.
//  Top level holds the shadow bank, the command decoder and the FSM.
// TESTING
//  1. Reset, then no words -> band_gain = {8{8'h80}}, err_code = 0, upd_cnt = 0, cfg_busy = 0.
//  2. WRITE band 3 = 0x40, COMMIT, tick 5 cycles later -> band_gain[31:24] = 0x40 only after the tick;
//     upd_cnt = 1; cfg_busy high only between COMMIT and the apply.
//  3. WRITE band 9 (NBANDS = 8) -> err_code = 2, shadow unchanged;
//     opcode 0xF -> err_code = 1; CLR_ERR -> err_code = 0.
//  4. COMMIT, then WRITE before any tick -> err_code = 3, write dropped;
//     tick -> old shadow applied.
//  5. EQ_RAMP_EN: band 0 from 0x80 to 0x83, COMMIT, ticks -> 0x81, 0x82, 0x83 on
//     successive ticks after entering RAMP; upd_cnt++ on reaching target.
//  6. Reset asserted in WAIT_TICK, then tick -> band_gain stays at default;
//     256 empty commits -> upd_cnt wraps to 0.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared constants and types for the EQ configuration controller.
package eq_pkg;

    localparam int         NBANDS_MAX   = 16;
    localparam logic [7:0] GAIN_DEFAULT = 8'h80;

    typedef enum logic [3:0] {
        OP_WRITE   = 4'h1,
        OP_COMMIT,
        OP_DEFAULT,
        OP_CLR_ERR
    } eq_op_e;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_OPCODE,
        ERR_BAND,
        ERR_OVERRUN
    } eq_err_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_RAMP
    } eq_state_e;

endpackage

// File: rtl/eq_gain_ramp.sv
// One band of active gain that walks 1 LSB per step toward its target,
// never overshooting. Used only in the EQ_RAMP_EN build.
module eq_gain_ramp #(
    parameter int                GAIN_W       = 8,
    parameter logic [GAIN_W-1:0] GAIN_DEFAULT = GAIN_W'(eq_pkg::GAIN_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    input  logic [GAIN_W-1:0] target,
    output logic [GAIN_W-1:0] value,
    output logic              at_target
);

    assign at_target = (value == target);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= GAIN_DEFAULT;
        end else if (step && !at_target) begin
            if (value < target)
                value <= value + GAIN_W'(1);
            else
                value <= value - GAIN_W'(1);
        end
    end

endmodule

// File: rtl/eq_cfg_ctrl.sv
// EQ configuration controller: decodes command words into a shadow gain bank and
// commits it to the active bank on a sample tick. Optional macro EQ_RAMP_EN ramps gains.
module eq_cfg_ctrl #(
    parameter int                NBANDS       = 8,
    parameter int                GAIN_W       = 8,
    parameter logic [GAIN_W-1:0] GAIN_DEFAULT = GAIN_W'(eq_pkg::GAIN_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     word_valid,
    input  logic [31:0]              word_data,
    input  logic                     sample_tick,
    output logic [NBANDS*GAIN_W-1:0] band_gain,
    output logic                     cfg_busy,
    output logic [1:0]               err_code,
    output logic [7:0]               upd_cnt
);
    import eq_pkg::*;

    eq_state_e         state_q, state_d;
    eq_err_e           err_q, err_d;
    logic [GAIN_W-1:0] shadow_q [NBANDS];
    logic [GAIN_W-1:0] active   [NBANDS];

    logic [3:0]        op;
    logic [3:0]        band;
    logic [GAIN_W-1:0] gain;
    logic              band_ok;
    logic              wr_en;
    logic              def_en;
    logic              done;
    logic              unused_word;

`ifdef EQ_RAMP_EN
    logic              ramp_step;
    logic [NBANDS-1:0] at_vec;
    logic              all_at;
`endif

    assign op          = word_data[31:28];
    assign band        = word_data[27:24];
    assign gain        = word_data[GAIN_W-1:0];
    assign unused_word = ^word_data[23:GAIN_W];
    assign band_ok     = ({1'b0, band} < 5'(NBANDS));

    assign cfg_busy = (state_q != S_IDLE);
    assign err_code = err_q;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        def_en  = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (word_valid) begin
                    case (op)
                        OP_WRITE: begin
                            if (band_ok) wr_en = 1'b1;
                            else         err_d = ERR_BAND;
                        end
                        OP_COMMIT:  state_d = S_WAIT_TICK;
                        OP_DEFAULT: def_en  = 1'b1;
                        OP_CLR_ERR: err_d   = ERR_NONE;
                        default:    err_d   = ERR_OPCODE;
                    endcase
                end
            end
            S_WAIT_TICK: begin
                // A word landing with the tick is still an overrun; the tick wins.
                if (word_valid) err_d = ERR_OVERRUN;
                if (sample_tick) begin
`ifdef EQ_RAMP_EN
                    state_d = S_RAMP;
`else
                    done    = 1'b1;
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef EQ_RAMP_EN
            S_RAMP: begin
                if (word_valid) err_d = ERR_OVERRUN;
                if (all_at) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            err_q   <= ERR_NONE;
            upd_cnt <= 8'd0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (done) upd_cnt <= upd_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NBANDS; i++) begin
            if (reset || def_en)
                shadow_q[i] <= GAIN_DEFAULT;
            else if (wr_en && band == 4'(i))
                shadow_q[i] <= gain;
        end
    end

`ifdef EQ_RAMP_EN
    assign ramp_step = (state_q == S_RAMP) && sample_tick;
    assign all_at    = &at_vec;
`else
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBANDS; i++) begin
            if (reset)
                active[i] <= GAIN_DEFAULT;
            else if (done)
                active[i] <= shadow_q[i];
        end
    end
`endif

    for (genvar i = 0; i < NBANDS; i++) begin : g_band
`ifdef EQ_RAMP_EN
        eq_gain_ramp #(
            .GAIN_W       (GAIN_W),
            .GAIN_DEFAULT (GAIN_DEFAULT)
        ) u_ramp (
            .clk       (clk),
            .reset     (reset),
            .step      (ramp_step),
            .target    (shadow_q[i]),
            .value     (active[i]),
            .at_target (at_vec[i])
        );
`endif
        assign band_gain[i*GAIN_W +: GAIN_W] = active[i];
    end

endmodule

// File: tb/tb_eq_cfg_ctrl.sv
// Scoreboard bench for eq_cfg_ctrl: a command-level reference model predicts the
// outputs after every clock edge; a monitor compares them on the falling edge.
module tb_eq_cfg_ctrl;

    localparam int         NB   = 8;
    localparam int         GW   = 8;
    localparam logic [7:0] GDEF = 8'h80;

    logic             clk = 1'b0;
    logic             reset;
    logic             word_valid;
    logic [31:0]      word_data;
    logic             sample_tick;
    logic [NB*GW-1:0] band_gain;
    logic             cfg_busy;
    logic [1:0]       err_code;
    logic [7:0]       upd_cnt;

    eq_cfg_ctrl #(.NBANDS(NB), .GAIN_W(GW), .GAIN_DEFAULT(GDEF)) dut (
        .clk         (clk),
        .reset       (reset),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .sample_tick (sample_tick),
        .band_gain   (band_gain),
        .cfg_busy    (cfg_busy),
        .err_code    (err_code),
        .upd_cnt     (upd_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NB*GW-1:0] g;
        logic             busy;
        logic [1:0]       err;
        logic [7:0]       cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: gain banks as integer arrays plus "commit pending" flags.
    int sh  [NB];
    int act [NB];
    bit pending;
    bit ramping;
    int err_m;
    int cnt_m;

    function automatic bit banks_equal();
        for (int i = 0; i < NB; i++)
            if (sh[i] != act[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_edge(input bit r, input bit wv, input logic [31:0] wd, input bit tk);
        int op;
        int bnd;
        op  = int'(wd[31:28]);
        bnd = int'(wd[27:24]);
        if (r) begin
            for (int i = 0; i < NB; i++) begin
                sh[i]  = int'(GDEF);
                act[i] = int'(GDEF);
            end
            pending = 1'b0;
            ramping = 1'b0;
            err_m   = 0;
            cnt_m   = 0;
        end else if (!pending) begin
            if (wv) begin
                if (op == 1) begin
                    if (bnd < NB) sh[bnd] = int'(wd[7:0]);
                    else          err_m = 2;
                end else if (op == 2) pending = 1'b1;
                else if (op == 3) begin
                    for (int i = 0; i < NB; i++) sh[i] = int'(GDEF);
                end else if (op == 4) err_m = 0;
                else err_m = 1;
            end
        end else begin
            if (wv) err_m = 3;
            if (ramping) begin
                if (banks_equal()) begin
                    cnt_m   = (cnt_m + 1) % 256;
                    pending = 1'b0;
                    ramping = 1'b0;
                end else if (tk) begin
                    for (int i = 0; i < NB; i++) begin
                        if (act[i] < sh[i])      act[i] = act[i] + 1;
                        else if (act[i] > sh[i]) act[i] = act[i] - 1;
                    end
                end
            end else if (tk) begin
`ifdef EQ_RAMP_EN
                ramping = 1'b1;
`else
                for (int i = 0; i < NB; i++) act[i] = sh[i];
                cnt_m   = (cnt_m + 1) % 256;
                pending = 1'b0;
`endif
            end
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        for (int i = 0; i < NB; i++) e.g[i*GW +: GW] = act[i][7:0];
        e.busy = pending;
        e.err  = err_m[1:0];
        e.cnt  = cnt_m[7:0];
        exp_q.push_back(e);
    endfunction

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, got, req, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("band_gain", 64'(band_gain), 64'(mon_e.g));
            chk("cfg_busy",  64'(cfg_busy),  64'(mon_e.busy));
            chk("err_code",  64'(err_code),  64'(mon_e.err));
            chk("upd_cnt",   64'(upd_cnt),   64'(mon_e.cnt));
        end
    end

    function automatic logic [31:0] mkw(input logic [3:0] op, input logic [3:0] bnd, input logic [7:0] g);
        return {op, bnd, 16'($urandom), g};
    endfunction

    task automatic cyc(input bit r, input bit wv, input logic [31:0] wd, input bit tk);
        reset       = r;
        word_valid  = wv;
        word_data   = wd;
        sample_tick = tk;
        @(posedge clk);
        model_edge(r, wv, wd, tk);
        push_exp();
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic word(input logic [3:0] op, input logic [3:0] bnd, input logic [7:0] g);
        cyc(1'b0, 1'b1, mkw(op, bnd, g), 1'b0);
    endtask

    task automatic tick();
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    // Tick every cycle until the model's commit completes (bounded).
    task automatic settle();
        for (int k = 0; k < 600 && pending; k++) tick();
    endtask

    logic [3:0] r_op;
    logic [3:0] r_band;
    logic [7:0] r_g;
    int         r_sel;

    initial begin
        reset       = 1'b1;
        word_valid  = 1'b0;
        word_data   = 32'h0;
        sample_tick = 1'b0;

        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (3) idle();

        word(4'h1, 4'd3, 8'h40);
        word(4'h2, 4'd0, 8'h00);
        repeat (5) idle();
        settle();
        repeat (2) idle();

        word(4'h1, 4'd9, 8'h55);
        idle();
        word(4'hF, 4'd0, 8'h00);
        idle();
        word(4'h4, 4'd0, 8'h00);
        idle();

        word(4'h2, 4'd0, 8'h00);
        word(4'h1, 4'd0, 8'h11);
        idle();
        cyc(1'b0, 1'b1, mkw(4'h1, 4'd1, 8'h22), 1'b1);
        settle();
        word(4'h4, 4'd0, 8'h00);

        word(4'h3, 4'd0, 8'h00);
        word(4'h2, 4'd0, 8'h00);
        settle();
        word(4'h1, 4'd0, 8'h83);
        word(4'h2, 4'd0, 8'h00);
        idle();
        for (int k = 0; k < 6; k++) begin
            tick();
            idle();
        end

        word(4'h1, 4'd5, 8'h10);
        word(4'h2, 4'd0, 8'h00);
        idle();
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        repeat (2) idle();

        for (int k = 0; k < 256; k++) begin
            word(4'h2, 4'd0, 8'h00);
            settle();
        end
        idle();

        for (int k = 0; k < 2500; k++) begin
            r_sel = $urandom_range(0, 9);
            if (r_sel < 4)       r_op = 4'h1;
            else if (r_sel < 6)  r_op = 4'h2;
            else if (r_sel == 6) r_op = 4'h3;
            else if (r_sel == 7) r_op = 4'h4;
            else                 r_op = 4'($urandom);
            r_band = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
            r_g    = 8'($urandom);
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
                mkw(r_op, r_band, r_g), $urandom_range(0, 2) == 0);
        end

        repeat (2) idle();
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
